// File: rtl/cfg_wr_master.sv
// rtl/cfg_wr_master.sv - cfg write bus initiator with request FIFO and programmable inter-write gap
module cfg_wr_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  cfg_vld,
  output logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  busy,
  output logic [15:0]           wr_cnt
);

  localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_next;

  logic                  push, pop;
  logic                  cfg_vld_next;
  logic [ADDR_WIDTH-1:0] cfg_addr_next;
  logic [DATA_WIDTH-1:0] cfg_data_next;
  logic [15:0]           wr_cnt_next;
  logic                  req_rdy_next;
  logic                  busy_next;

  // req_rdy is registered from the post-update count, so it always mirrors "FIFO not full"
  assign push = req_vld && req_rdy;

  // FIFO storage: plain RAM, contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= req_addr;
      mem_data[wr_ptr] <= req_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: an issue enters GAP unless back-to-back mode; GAP ends on its last count
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count != '0) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: pop/issue in IDLE, count down the idle gap in GAP
  always_comb begin
    pop           = 1'b0;
    cfg_vld_next  = 1'b0;
    cfg_addr_next = cfg_addr;
    cfg_data_next = cfg_data;
    wr_cnt_next   = wr_cnt;
    gap_cnt_next  = gap_cnt;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop           = 1'b1;
          cfg_vld_next  = 1'b1;
          cfg_addr_next = mem_addr[rd_ptr];
          cfg_data_next = mem_data[rd_ptr];
          wr_cnt_next   = wr_cnt + 16'd1;
          gap_cnt_next  = GAP_W'(GAP_CYCLES);
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt - GAP_W'(1);
      end
      default: ;
    endcase
  end

  // Status computed from next-state values so registered outputs line up with the FIFO/FSM
  always_comb begin
    req_rdy_next = (count_next != CNT_W'(FIFO_DEPTH));
    busy_next    = (count_next != '0) || (state_next != IDLE) || cfg_vld_next;
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_vld  <= 1'b0;
      cfg_addr <= '0;
      cfg_data <= '0;
      wr_cnt   <= '0;
      gap_cnt  <= '0;
      req_rdy  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cfg_vld  <= cfg_vld_next;
      cfg_addr <= cfg_addr_next;
      cfg_data <= cfg_data_next;
      wr_cnt   <= wr_cnt_next;
      gap_cnt  <= gap_cnt_next;
      req_rdy  <= req_rdy_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_cfg_wr_master.sv
// tb/tb_cfg_wr_master.sv - randomized scoreboard bench for cfg_wr_master at gaps 0, 1 and 3
module tb_cfg_wr_master;

  localparam int NDUT  = 3;
  localparam int DEPTH = 4;

  typedef struct {
    int          t;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld  [NDUT];
  logic        req_rdy  [NDUT];
  logic [31:0] req_addr [NDUT];
  logic [31:0] req_data [NDUT];
  logic        cfg_vld  [NDUT];
  logic [31:0] cfg_addr [NDUT];
  logic [31:0] cfg_data [NDUT];
  logic        busy     [NDUT];
  logic [15:0] wr_cnt   [NDUT];

  logic        acc   [NDUT];
  logic [31:0] acc_a [NDUT];
  logic [31:0] acc_d [NDUT];
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Record handshakes as seen just before each edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NDUT; i++) begin
      acc[i]   <= req_vld[i] && req_rdy[i];
      acc_a[i] <= req_addr[i];
      acc_d[i] <= req_data[i];
    end
  end

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int GAP = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    localparam int BUSY_WIN = (GAP > 0) ? GAP : 1;

    cfg_wr_master #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .FIFO_DEPTH(DEPTH),
      .GAP_CYCLES(GAP)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req_vld (req_vld[g]),
      .req_rdy (req_rdy[g]),
      .req_addr(req_addr[g]),
      .req_data(req_data[g]),
      .cfg_vld (cfg_vld[g]),
      .cfg_addr(cfg_addr[g]),
      .cfg_data(cfg_data[g]),
      .busy    (busy[g]),
      .wr_cnt  (wr_cnt[g])
    );

    // Reference: write n is issued at max(accept+1, previous issue+GAP+1)
    exp_t        q[$];
    exp_t        e;
    int          last_sched;
    int          last_iss;
    int          issued;
    logic [31:0] last_a;
    logic [31:0] last_d;
    logic        pulse_exp;

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        last_sched = -1000;
        last_iss   = -1000;
        issued     = 0;
        last_a     = '0;
        last_d     = '0;
      end else begin
        if (acc[g]) begin
          e.t = (cyc + 1 > last_sched + GAP + 1) ? cyc + 1 : last_sched + GAP + 1;
          e.a = acc_a[g];
          e.d = acc_d[g];
          q.push_back(e);
          last_sched = e.t;
        end
        pulse_exp = 1'b0;
        if (q.size() != 0) begin
          if (q[0].t == cyc) pulse_exp = 1'b1;
        end
        check("cfg_vld", cfg_vld[g], pulse_exp);
        if (cfg_vld[g] && q.size() != 0) begin
          check("cfg_addr", cfg_addr[g], q[0].a);
          check("cfg_data", cfg_data[g], q[0].d);
          last_a = q[0].a;
          last_d = q[0].d;
          void'(q.pop_front());
          issued++;
          last_iss = cyc;
        end else if (!cfg_vld[g]) begin
          check("hold_addr", cfg_addr[g], last_a);
          check("hold_data", cfg_data[g], last_d);
        end
        check("wr_cnt", wr_cnt[g], issued & 16'hFFFF);
        check("req_rdy", req_rdy[g], q.size() != DEPTH);
        check("busy", busy[g], (q.size() != 0) || (cyc - last_iss < BUSY_WIN));
      end
    end
  end

  // Offer one request starting just after a negedge; returns after the accepting edge
  task automatic push(input int i, input logic [31:0] a, input logic [31:0] d);
    int   n;
    logic ok;
    n = 0;
    req_vld[i]  = 1'b1;
    req_addr[i] = a;
    req_data[i] = d;
    do begin
      ok = req_rdy[i];
      @(negedge clk);
      n++;
    end while (!ok && n < 200);
    check("push_timeout", ok, 1'b1);
    req_vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy[i], 1'b0);
  endtask

  task automatic rand_traffic(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(i, $urandom, $urandom);
    end
  endtask

  logic stalled;

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      req_vld[i]  = 1'b0;
      req_addr[i] = '0;
      req_data[i] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("rst_req_rdy", req_rdy[i], 1'b0);
      check("rst_cfg_vld", cfg_vld[i], 1'b0);
      check("rst_cfg_addr", cfg_addr[i], 32'h0);
      check("rst_cfg_data", cfg_data[i], 32'h0);
      check("rst_busy", busy[i], 1'b0);
      check("rst_wr_cnt", wr_cnt[i], 16'h0);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check("rdy_after_release", req_rdy[i], 1'b1);

    // Single write, gap 1
    push(1, 32'h10, 32'hA5A5A5A5);
    @(negedge clk);
    check("t1_vld", cfg_vld[1], 1'b1);
    check("t1_addr", cfg_addr[1], 32'h10);
    check("t1_data", cfg_data[1], 32'hA5A5A5A5);
    @(negedge clk);
    check("t1_vld_low", cfg_vld[1], 1'b0);
    check("t1_busy", busy[1], 1'b0);
    check("t1_wr_cnt", wr_cnt[1], 16'd1);

    // Back-to-back, gap 0
    for (int k = 0; k < 4; k++) push(0, k, $urandom);
    wait_idle(0);
    check("t2_wr_cnt", wr_cnt[0], 16'd4);

    // Gap 3, six writes against a depth-4 FIFO: must stall and hold the request
    stalled = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!req_rdy[2]) stalled = 1'b1;
      push(2, 32'h100 + k, $urandom);
    end
    wait_idle(2);
    check("t3_stalled", stalled, 1'b1);
    check("t3_wr_cnt", wr_cnt[2], 16'd6);

    // Random concurrent traffic
    fork
      rand_traffic(0, 40);
      rand_traffic(1, 40);
      rand_traffic(2, 40);
    join
    for (int i = 0; i < NDUT; i++) wait_idle(i);

    // Reset with 3 queued and mid-gap
    for (int k = 0; k < 4; k++) push(2, 32'h200 + k, $urandom);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("t5_cfg_vld", cfg_vld[i], 1'b0);
      check("t5_wr_cnt", wr_cnt[i], 16'h0);
      check("t5_busy", busy[i], 1'b0);
      check("t5_req_rdy", req_rdy[i], 1'b0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t5_no_write", cfg_vld[2], 1'b0);
    end
    push(2, 32'h300, 32'h12345678);
    wait_idle(2);
    check("t5_new_write", wr_cnt[2], 16'd1);

    // Counter wrap, gap 0
    for (int k = 0; k < 65536; k++) push(0, $urandom, $urandom);
    wait_idle(0);
    check("t6_wrap", wr_cnt[0], 16'h0000);
    push(0, $urandom, $urandom);
    wait_idle(0);
    check("t6_after_wrap", wr_cnt[0], 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
